avalon_st_pkt_arbiter: RTL and testbench
========================================

Name: avalon_st_pkt_arbiter

Overview:
Packet-atomic round-robin arbiter that shares one Avalon-ST output among N_PORTS Avalon-ST sources.
Once a source wins, the block holds it until its eop word is accepted, so packets never interleave on msg_out.
The block also counts words per granted packet for on-board debug.
It sits in front of shared sinks such as the debug word counter and UART/packet sinks.

Parameters:
N_PORTS, 4, number of requesting sources (>=1)
WORD_COUNTER_SIZE, 8, width of the per-packet word count; the count saturates at all-ones
GRANT_W, derived = max(1, $clog2(N_PORTS)), width of the grant index (localparam)

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
msg_in[N_PORTS]  avalon_st_if.slave  -  requesting streams (valid/ready/sop/eop/data)
msg_out  avalon_st_if.master  -  shared output stream
busy  output  1  a packet is currently granted
grant_idx  output  GRANT_W  index of the granted source; holds the last winner when idle
pkt_done  output  1  one-cycle pulse when an eop handshake completes on msg_out
pkt_words  output  WORD_COUNTER_SIZE  word count of the last completed packet, valid from the pkt_done cycle onward
orphan_drop  output  1  one-cycle pulse when a non-sop word is discarded while idle

Behaviour:
- Reset values: state IDLE, busy=0, grant_idx=0, last_grant=N_PORTS-1 (so port 0 has top priority after reset), word count 0, pkt_words=0, pkt_done=0, orphan_drop=0. While in reset all msg_in.ready=0 and msg_out.valid=0.
- FSM states: IDLE and LOCKED.
- IDLE, candidate selection:
  - Candidates are ports with valid & sop.
  - The winner is the first candidate searching last_grant+1, +2, ... with modulo N_PORTS wrap.
  - On a winner: register grant_idx, go to LOCKED next cycle (1-cycle arbitration latency), busy=1.
  - No data moves in IDLE: msg_out.valid=0.
- IDLE, orphan words:
  - Ports with valid & ~sop are drained: ready=1, word discarded.
  - orphan_drop pulses the following cycle if any word was dropped.
  - A port that is a candidate gets ready=0 in IDLE.
- LOCKED:
  - msg_out valid/sop/eop/data combinationally mirror msg_in[grant_idx].
  - msg_in[grant_idx].ready = msg_out.ready; all other readys = 0.
  - Zero-latency pass-through; no buffering.
- Word count: increments on each msg_out handshake (valid & ready) in LOCKED and saturates at 2^WORD_COUNTER_SIZE-1.
- On an eop handshake:
  - pkt_words <= count including the eop word.
  - count <= 0.
  - pkt_done pulses the next cycle.
  - last_grant <= grant_idx.
  - Return to IDLE; the next arbitration occurs in that IDLE cycle.
  - Minimum spacing between packets is one idle cycle.
- Single-word packet (sop & eop in one handshake): count=1, immediate return to IDLE.
- sop seen mid-packet on the granted port: forwarded unchanged; the lock persists until eop.
- Granted source drops valid mid-packet: the lock is held indefinitely. No timeout.
- Backpressure: the word count and lock are unaffected while msg_out.ready=0.
- Async reset mid-packet: everything returns to reset values immediately; the partial packet is abandoned.
- N_PORTS=1: the arbiter degenerates to always granting port 0; grant_idx is a constant 0.

Decomposition:
- Package avalon_st_arb_pkg:
  - typedef enum logic {IDLE, LOCKED} arb_state_t
  - function rr_next(req, last) returning the winning index
- Sub-module rr_priority_picker:
  - Combinational round-robin picker: N-bit request vector and last_grant in, found flag and index out.
  - Reusable by other debug arbiters.
- Top level owns the FSM, word counter and interface muxing.

Test Plan:
- Reset then a single request: port 2 sends a 3-word packet -> grant_idx=2 one cycle after sop; msg_out carries 3 words; pkt_done pulses once; pkt_words=3.
- Round-robin fairness: ports 0,1,3 all hold sop-valid continuously with 2-word packets -> grant order 0,1,3,0,1,3; no word interleaving; port 2 is never granted.
- Backpressure: msg_out.ready toggles 1,0,0,1 during a 4-word packet from port 1 -> no words lost or duplicated; msg_in[1].ready tracks msg_out.ready; pkt_words=4.
- Orphan and single-word: port 0 presents valid without sop in IDLE -> consumed, orphan_drop pulses once. Then port 0 sends sop&eop -> pkt_words=1 and an immediate return to IDLE.
- Saturation: with WORD_COUNTER_SIZE=4, a 20-word packet -> pkt_words=15, and the data stream is still complete.
- Reset mid-packet: assert rst_n=0 at word 2 of 5 -> busy=0, msg_out.valid=0 immediately. After release, port 0 wins first if it requests.

Source files
------------

// File: rtl/avalon_st_arb_pkg.sv
// avalon_st_arb_pkg: shared types and the round-robin search used by the packet arbiter.
package avalon_st_arb_pkg;

    localparam int DATA_W    = 8;
    localparam int MAX_PORTS = 32;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    // First requester after `last`, wrapping modulo n; returns `last` when nothing requests.
    function automatic logic [31:0] rr_next(
        input logic [MAX_PORTS-1:0] req,
        input logic [31:0]          last,
        input logic [31:0]          n
    );
        logic [31:0] p;
        rr_next = last;
        for (int i = MAX_PORTS; i >= 1; i--) begin
            p = last + 32'(i);
            p = (p >= n) ? p - n : p;
            if (32'(i) <= n && req[p[4:0]]) rr_next = p;
        end
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// avalon_st_if: Avalon-ST handshake bundle (valid/ready/sop/eop/data).
interface avalon_st_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;

    modport master (output valid, sop, eop, data, input ready);
    modport slave  (input valid, sop, eop, data, output ready);
endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick starting just after last.
module rr_priority_picker
    import avalon_st_arb_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = W'(rr_next(MAX_PORTS'(req), 32'(last), 32'(N)));
    end

endmodule

// File: rtl/avalon_st_pkt_arbiter.sv
// avalon_st_pkt_arbiter: packet-atomic round-robin mux of N Avalon-ST sources onto one sink,
// with a saturating per-packet word count for debug.
module avalon_st_pkt_arbiter
    import avalon_st_arb_pkg::*;
#(
    parameter  int N_PORTS           = 4,
    parameter  int WORD_COUNTER_SIZE = 8,
    localparam int GRANT_W           = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    avalon_st_if.slave                   msg_in [N_PORTS],
    avalon_st_if.master                  msg_out,
    output logic                         busy,
    output logic [GRANT_W-1:0]           grant_idx,
    output logic                         pkt_done,
    output logic [WORD_COUNTER_SIZE-1:0] pkt_words,
    output logic                         orphan_drop
);

    arb_state_t                   state_q, state_d;
    logic [GRANT_W-1:0]           grant_q, grant_d, last_q, last_d, pick;
    logic [WORD_COUNTER_SIZE-1:0] cnt_q, cnt_d, cnt_inc, pkt_words_q, pkt_words_d;
    logic                         pkt_done_q, pkt_done_d, orphan_q, orphan_d;
    logic                         locked, hs, found;
    logic [N_PORTS-1:0]           in_valid, in_sop, in_eop, in_ready;
    logic [DATA_W-1:0]            in_data [N_PORTS];

    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        assign in_valid[g]     = msg_in[g].valid;
        assign in_sop[g]       = msg_in[g].sop;
        assign in_eop[g]       = msg_in[g].eop;
        assign in_data[g]      = msg_in[g].data;
        assign msg_in[g].ready = in_ready[g];
    end

    rr_priority_picker #(.N(N_PORTS)) u_pick (
        .req   (in_valid & in_sop),
        .last  (last_q),
        .found (found),
        .idx   (pick)
    );

    assign locked        = state_q == LOCKED;
    assign msg_out.valid = locked & in_valid[grant_q];
    assign msg_out.sop   = in_sop[grant_q];
    assign msg_out.eop   = in_eop[grant_q];
    assign msg_out.data  = in_data[grant_q];
    assign hs            = msg_out.valid & msg_out.ready;

    // Idle drains non-sop words so a stray tail cannot wedge a source; pending sops wait for the grant.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++)
            in_ready[i] = rst_n & (locked ? (GRANT_W'(i) == grant_q) & msg_out.ready
                                          : in_valid[i] & ~in_sop[i]);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        pkt_words_d = pkt_words_q;
        pkt_done_d  = 1'b0;
        orphan_d    = 1'b0;
        cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + WORD_COUNTER_SIZE'(1);
        if (!locked) begin
            orphan_d = |(in_valid & ~in_sop);
            if (found) begin
                state_d = LOCKED;
                grant_d = pick;
            end
        end else if (hs) begin
            cnt_d = cnt_inc;
            if (msg_out.eop) begin
                pkt_words_d = cnt_inc;
                cnt_d       = '0;
                pkt_done_d  = 1'b1;
                last_d      = grant_q;
                state_d     = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= GRANT_W'(N_PORTS - 1);
            cnt_q       <= '0;
            pkt_words_q <= '0;
            pkt_done_q  <= 1'b0;
            orphan_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            pkt_words_q <= pkt_words_d;
            pkt_done_q  <= pkt_done_d;
            orphan_q    <= orphan_d;
        end
    end

    assign busy        = locked;
    assign grant_idx   = grant_q;
    assign pkt_done    = pkt_done_q;
    assign pkt_words   = pkt_words_q;
    assign orphan_drop = orphan_q;

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// tb_avalon_st_pkt_arbiter: queue-driven sources with an expected-word scoreboard on msg_out.
module tb_avalon_st_pkt_arbiter;

    localparam int NP  = 4;
    localparam int WCS = 4;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } word_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NP-1:0]  tb_valid = '0, tb_sop = '0, tb_eop = '0, tb_ready;
    logic [7:0]     tb_data [NP];
    logic           out_ready = 1'b1;
    logic           busy, pkt_done, orphan_drop;
    logic [1:0]     grant_idx;
    logic [WCS-1:0] pkt_words;

    word_t          src_q [NP][$];
    word_t          exp_q [$];
    logic [WCS-1:0] words_q [$];
    logic           rdy_pat [$];
    int             n_chk = 0, n_pass = 0, n_orph = 0, n_done = 0;

    avalon_st_if in_if [NP] ();
    avalon_st_if out_if ();

    for (genvar g = 0; g < NP; g++) begin : g_src
        assign in_if[g].valid = tb_valid[g];
        assign in_if[g].sop   = tb_sop[g];
        assign in_if[g].eop   = tb_eop[g];
        assign in_if[g].data  = tb_data[g];
        assign tb_ready[g]    = in_if[g].ready;
    end
    assign out_if.ready = out_ready;

    avalon_st_pkt_arbiter #(.N_PORTS(NP), .WORD_COUNTER_SIZE(WCS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .msg_in      (in_if),
        .msg_out     (out_if),
        .busy        (busy),
        .grant_idx   (grant_idx),
        .pkt_done    (pkt_done),
        .pkt_words   (pkt_words),
        .orphan_drop (orphan_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    task automatic load_pkt(input int p, input int n);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.sop  = (i == 0);
            w.eop  = (i == n - 1);
            w.data = {2'(p), 6'(i)};
            src_q[p].push_back(w);
            exp_q.push_back(w);
        end
        words_q.push_back(WCS'((n > 15) ? 15 : n));
    endtask

    function automatic bit src_pending();
        src_pending = 1'b0;
        for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) src_pending = 1'b1;
    endfunction

    // One cycle: drive at negedge, sample settled values, retire handshakes due at the next posedge.
    task automatic step();
        word_t          w;
        logic [NP-1:0]  exp_rdy;
        logic [WCS-1:0] ew;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            tb_valid[p] = src_q[p].size() != 0;
            w = tb_valid[p] ? src_q[p][0] : '0;
            {tb_sop[p], tb_eop[p], tb_data[p]} = w;
        end
        out_ready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
        #1;
        if (pkt_done) begin
            n_done++;
            if (words_q.size() == 0) chk("unexpected_pkt_done", 32'(1), 32'(0));
            else begin
                ew = words_q.pop_front();
                chk("pkt_words", 32'(pkt_words), 32'(ew));
            end
        end
        if (orphan_drop) n_orph++;
        if (!busy) chk("idle_out_valid", 32'(out_if.valid), 32'(0));
        exp_rdy = busy ? (NP'(out_ready) << grant_idx) : (tb_valid & ~tb_sop);
        chk("in_ready", 32'(tb_ready), 32'(exp_rdy));
        if (out_if.valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_word", 32'(1), 32'(0));
            else begin
                w = exp_q.pop_front();
                chk("out_word", 32'({out_if.sop, out_if.eop, out_if.data}), 32'(w));
            end
        end
        for (int p = 0; p < NP; p++)
            if (tb_valid[p] && tb_ready[p]) void'(src_q[p].pop_front());
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || words_q.size() != 0 || busy || src_pending()) && k < 300) begin
            step();
            k++;
        end
        chk({tag, "_timeout"}, 32'(k < 300), 32'(1));
        chk({tag, "_leftover"}, 32'(exp_q.size() + words_q.size()), 32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        words_q.delete();
        rdy_pat.delete();
        tb_valid  = '0;
        tb_sop    = '0;
        tb_eop    = '0;
        out_ready = 1'b1;
        n_orph    = 0;
        n_done    = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        word_t w;
        int    k;
        for (int p = 0; p < NP; p++) tb_data[p] = '0;

        do_reset();
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_grant", 32'(grant_idx), 32'(0));
        chk("rst_pkt_words", 32'(pkt_words), 32'(0));
        chk("rst_pkt_done", 32'(pkt_done), 32'(0));
        chk("rst_orphan", 32'(orphan_drop), 32'(0));

        load_pkt(2, 3);
        step();
        chk("t1_arb_busy", 32'(busy), 32'(0));
        step();
        chk("t1_busy", 32'(busy), 32'(1));
        chk("t1_grant", 32'(grant_idx), 32'(2));
        drain("t1");
        chk("t1_done_count", 32'(n_done), 32'(1));

        do_reset();
        for (int r = 0; r < 2; r++) begin
            load_pkt(0, 2);
            load_pkt(1, 2);
            load_pkt(3, 2);
        end
        drain("rr");
        chk("rr_done_count", 32'(n_done), 32'(6));

        do_reset();
        load_pkt(1, 4);
        for (int i = 0; i < 8; i++) rdy_pat.push_back(i inside {2, 3, 6} ? 1'b0 : 1'b1);
        drain("bp");
        chk("bp_done_count", 32'(n_done), 32'(1));

        do_reset();
        w = {1'b0, 1'b0, 8'hAA};
        src_q[0].push_back(w);
        load_pkt(0, 1);
        step();
        chk("orph_consumed", 32'(src_q[0].size()), 32'(1));
        step();
        chk("orph_pulse", 32'(orphan_drop), 32'(1));
        step();
        chk("single_busy", 32'(busy), 32'(1));
        step();
        chk("single_back_idle", 32'(busy), 32'(0));
        chk("single_done", 32'(pkt_done), 32'(1));
        drain("single");
        chk("orph_count", 32'(n_orph), 32'(1));

        do_reset();
        load_pkt(2, 20);
        drain("sat");
        chk("sat_done_count", 32'(n_done), 32'(1));

        do_reset();
        load_pkt(3, 2);
        drain("pre");
        load_pkt(1, 5);
        k = 0;
        while (src_q[1].size() > 3 && k < 20) begin
            step();
            k++;
        end
        chk("mid_reach", 32'(k < 20), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_out_valid", 32'(out_if.valid), 32'(0));
        chk("mid_ready", 32'(tb_ready), 32'(0));
        chk("mid_grant", 32'(grant_idx), 32'(0));
        do_reset();
        load_pkt(0, 2);
        load_pkt(1, 2);
        load_pkt(3, 2);
        drain("post");
        chk("post_done_count", 32'(n_done), 32'(3));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
